// File: rtl/file_source_pacer.sv
// file_source_pacer
//   Paces a file-driven sample source into bursts of rows separated by
//   programmable idle gaps. It turns the source's free-running read enable
//   into a valid/ready stream for the DSP datapath under test.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   start, stop       start latches burstLen/gapLen/numBursts and begins;
//                     stop ends issuing early (the buffer still drains)
//   burstLen          rows per burst (0 = finish immediately with done)
//   gapLen            idle cycles between bursts
//   numBursts         bursts to run, 0 = run until stop
//   srcEn             read enable to the source, one row per high cycle
//   srcData           source row, valid the cycle after srcEn was high
//   outValid/outReady/outData  row stream to the datapath
//   busy              sequencer not idle
//   done              one-cycle pulse when a sequence completes
//   dbg_state         current sequencer state (IDLE=0 RUN=1 GAP=2 DRAIN=3)
//
// Handshake: a row moves on every rising edge where outValid && outReady.
// outValid never drops and outData never changes while a row is waiting
// (outValid && !outReady).
module file_source_pacer #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_NUM   = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           stop,
  input  logic [CNT_WIDTH-1:0]           burstLen,
  input  logic [CNT_WIDTH-1:0]           gapLen,
  input  logic [CNT_WIDTH-1:0]           numBursts,
  output logic                           srcEn,
  input  logic [DATA_WIDTH*DATA_NUM-1:0] srcData,
  output logic                           outValid,
  input  logic                           outReady,
  output logic [DATA_WIDTH*DATA_NUM-1:0] outData,
  output logic                           busy,
  output logic                           done,
  output logic [1:0]                     dbg_state
);

  localparam int RW = DATA_WIDTH * DATA_NUM;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cfg_burst;
  logic [CNT_WIDTH-1:0] cfg_gap;
  logic [CNT_WIDTH-1:0] cfg_num;
  logic [CNT_WIDTH-1:0] row_cnt;
  logic [CNT_WIDTH-1:0] burst_cnt;
  logic [CNT_WIDTH-1:0] gap_cnt;
  logic [CNT_WIDTH-1:0] row_inc;
  logic [CNT_WIDTH-1:0] burst_inc;
  logic [CNT_WIDTH-1:0] gap_inc;

  // Two-entry row buffer; inflight marks a row the source is returning now.
  logic          inflight;
  logic [RW-1:0] mem [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    occ;
  logic          push;
  logic          pop;
  logic [2:0]    occ_after;
  logic          drained;

  assign push      = inflight;
  assign outValid  = (occ != 2'd0);
  assign pop       = outValid && outReady;
  assign outData   = mem[rd_ptr];
  assign occ_after = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

  // Issue a read only if the row it returns next cycle is guaranteed a slot:
  // everything still owed to the buffer after this cycle's pop must be <= 1.
  assign srcEn = (state == RUN) && !stop && (row_cnt < cfg_burst) &&
                 (occ_after <= 3'd1);

  assign row_inc   = row_cnt + CNT_WIDTH'(1);
  assign burst_inc = burst_cnt + CNT_WIDTH'(1);
  assign gap_inc   = gap_cnt + CNT_WIDTH'(1);

  // Nothing left after this edge: no returning row and the buffer empties
  // with this cycle's pop. Looking ahead lets done land one cycle after the
  // final beat instead of two.
  assign drained = !inflight && (occ_after == 3'd0);

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      occ      <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      inflight <= srcEn;
      if (push) begin
        mem[wr_ptr] <= srcData;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ_after[1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cfg_burst <= '0;
      cfg_gap   <= '0;
      cfg_num   <= '0;
      row_cnt   <= '0;
      burst_cnt <= '0;
      gap_cnt   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            cfg_burst <= burstLen;
            cfg_gap   <= gapLen;
            cfg_num   <= numBursts;
            row_cnt   <= '0;
            burst_cnt <= '0;
            gap_cnt   <= '0;
            if (burstLen == '0) begin
              done <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state <= DRAIN;
          end else if (srcEn) begin
            row_cnt <= row_inc;
            if (row_inc == cfg_burst) begin
              burst_cnt <= burst_inc;
              if ((cfg_num != '0) && (burst_inc == cfg_num)) begin
                state <= DRAIN;
              end else if (cfg_gap != '0) begin
                state   <= GAP;
                gap_cnt <= '0;
              end else begin
                row_cnt <= '0;
              end
            end
          end
        end
        GAP: begin
          if (stop) begin
            state <= DRAIN;
          end else if (gap_inc == cfg_gap) begin
            state   <= RUN;
            row_cnt <= '0;
          end else begin
            gap_cnt <= gap_inc;
          end
        end
        DRAIN: begin
          if (drained) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A returning row must always find a free slot.
  assert property (@(posedge clk) disable iff (rst)
                   !(push && (occ == 2'd2) && !pop));

endmodule

// File: tb/tb_file_source_pacer.sv
module tb_file_source_pacer;

  localparam int DW = 16;
  localparam int DN = 8;
  localparam int CW = 16;
  localparam int RW = DW * DN;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic [CW-1:0] burstLen;
  logic [CW-1:0] gapLen;
  logic [CW-1:0] numBursts;
  logic          srcEn;
  logic [RW-1:0] srcData;
  logic          outValid;
  logic          outReady;
  logic [RW-1:0] outData;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  file_source_pacer #(
    .DATA_WIDTH(DW),
    .DATA_NUM  (DN),
    .CNT_WIDTH (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .burstLen (burstLen),
    .gapLen   (gapLen),
    .numBursts(numBursts),
    .srcEn    (srcEn),
    .srcData  (srcData),
    .outValid (outValid),
    .outReady (outReady),
    .outData  (outData),
    .busy     (busy),
    .done     (done),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            src_next = 0;
  logic          en_s     = 1'b0;
  logic [RW-1:0] exp_q[$];
  logic          en_hist[$];
  int            en_cnt    = 0;
  int            delivered = 0;
  int            done_cnt  = 0;
  int            done_cyc  = 0;
  int            last_beat = 0;
  logic          stalled   = 1'b0;
  logic [RW-1:0] hold_data = '0;

  task automatic check(input string tag, input logic [RW-1:0] got,
                       input logic [RW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Row n of the file: word k holds n*DN+k.
  function automatic logic [RW-1:0] make_row(input int idx);
    logic [RW-1:0] r;
    r = '0;
    for (int k = 0; k < DN; k++) r[k*DW +: DW] = DW'(idx * DN + k);
    return r;
  endfunction

  function automatic logic pick_ready(input int mode, input int i);
    if (mode == 1) return (i % 2 == 0);
    if (mode == 2) return ($urandom_range(0, 3) != 0);
    return 1'b1;
  endfunction

  always @(posedge clk) cyc++;

  // Source model: a row read in one cycle appears on srcData the next.
  always @(posedge clk) begin
    #1;
    if (en_s) begin
      srcData = make_row(src_next);
      src_next++;
    end
  end

  // Monitor: samples mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (rst) begin
      en_s    = 1'b0;
      stalled = 1'b0;
      exp_q.delete();
    end else begin
      en_s = srcEn;
      en_hist.push_back(srcEn);
      if (stalled && outValid) check("hold_stable", outData, hold_data);
      if (outValid && outReady) begin
        if (exp_q.size() == 0) check("unexpected_beat", RW'(outValid), RW'(1'b0));
        else check("row_data", outData, exp_q.pop_front());
        delivered++;
        last_beat = cyc;
      end
      if (srcEn) begin
        exp_q.push_back(make_row(src_next));
        en_cnt++;
      end
      check("outstanding_le_2", RW'(exp_q.size() <= 2), RW'(1'b1));
      stalled   = outValid && !outReady;
      hold_data = outData;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge. mode: 0 ready high, 1 toggling, 2 random.
  task automatic run_seq(input int bl, input int gl, input int nb,
                         input int mode, input int stop_after, input bit poke);
    int   exp_rows;
    int   i;
    bit   stopped;
    logic pat[$];
    stopped  = 1'b0;
    exp_rows = (stop_after > 0) ? stop_after : bl * nb;
    burstLen  = CW'(bl);
    gapLen    = CW'(gl);
    numBursts = CW'(nb);
    start     = 1'b1;
    stop      = 1'b0;
    outReady  = pick_ready(mode, 0);
    @(posedge clk); #1;
    start = 1'b0;
    en_hist.delete();
    en_cnt    = 0;
    delivered = 0;
    done_cnt  = 0;
    i = 0;
    while (done_cnt == 0 && i < 500) begin
      outReady = pick_ready(mode, i);
      if (poke && i == 2) begin
        start     = 1'b1;
        burstLen  = CW'(bl + 5);
        numBursts = CW'(nb + 2);
      end else begin
        start = 1'b0;
      end
      if (stop_after > 0 && !stopped && en_cnt == stop_after) begin
        stop    = 1'b1;
        stopped = 1'b1;
        #1 check("stop_blocks_srcEn", RW'(srcEn), RW'(1'b0));
      end else begin
        stop = 1'b0;
      end
      @(posedge clk); #1;
      i++;
    end
    start    = 1'b0;
    stop     = 1'b0;
    outReady = 1'b1;
    check("done_timeout", RW'(done_cnt != 0), RW'(1'b1));
    repeat (3) @(posedge clk);
    #1;
    check("done_once", RW'(done_cnt), RW'(1));
    check("busy_after_done", RW'(busy), RW'(1'b0));
    check("rows_issued", RW'(en_cnt), RW'(exp_rows));
    check("rows_delivered", RW'(delivered), RW'(exp_rows));
    check("queue_empty", RW'(exp_q.size()), RW'(0));
    if (exp_rows > 0) check("done_after_last_beat", RW'(done_cyc), RW'(last_beat + 1));
    // Unstalled srcEn waveform: bursts of bl ones separated by gl zeros.
    if (mode == 0 && stop_after == 0) begin
      for (int b = 0; b < nb; b++) begin
        for (int r = 0; r < bl; r++) pat.push_back(1'b1);
        if (b < nb - 1) for (int g = 0; g < gl; g++) pat.push_back(1'b0);
      end
      pat.push_back(1'b0);
      pat.push_back(1'b0);
      check("pattern_len", RW'(en_hist.size() >= pat.size()), RW'(1'b1));
      for (int k = 0; k < pat.size() && k < en_hist.size(); k++)
        check("srcEn_pattern", RW'(en_hist[k]), RW'(pat[k]));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; outReady = 1'b0;
    burstLen = '0; gapLen = '0; numBursts = '0; srcData = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_srcEn", RW'(srcEn), RW'(1'b0));
    check("reset_outValid", RW'(outValid), RW'(1'b0));
    check("reset_outData", outData, RW'(0));
    check("reset_busy", RW'(busy), RW'(1'b0));
    check("reset_done", RW'(done), RW'(1'b0));
    check("reset_state", RW'(dbg_state), RW'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    run_seq(4, 0, 1, 0, 0, 1'b0);
    run_seq(3, 2, 2, 0, 0, 1'b0);
    run_seq(8, 0, 1, 1, 0, 1'b0);
    run_seq(16, 0, 0, 0, 5, 1'b0);
    run_seq(2, 0, 1, 0, 0, 1'b0);

    // Zero-length burst: done next cycle, never busy, no reads.
    burstLen = '0; gapLen = CW'(3); numBursts = CW'(1); start = 1'b1;
    en_cnt = 0; done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
    check("zero_burst_done", RW'(done), RW'(1'b1));
    check("zero_burst_busy", RW'(busy), RW'(1'b0));
    @(posedge clk); #1;
    check("zero_burst_done_pulse", RW'(done), RW'(1'b0));
    repeat (2) @(posedge clk);
    #1;
    check("zero_burst_no_reads", RW'(en_cnt), RW'(0));
    check("zero_burst_done_count", RW'(done_cnt), RW'(1));

    // start together with stop in IDLE is ignored.
    burstLen = CW'(4); numBursts = CW'(1); start = 1'b1; stop = 1'b1;
    en_cnt = 0; done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    check("start_stop_busy", RW'(busy), RW'(1'b0));
    repeat (4) @(posedge clk);
    #1;
    check("start_stop_no_reads", RW'(en_cnt), RW'(0));
    check("start_stop_no_done", RW'(done_cnt), RW'(0));

    // start while busy (with new config on the inputs) changes nothing.
    run_seq(3, 0, 2, 0, 0, 1'b1);

    // Randomized sequences.
    for (int t = 0; t < 12; t++) begin
      run_seq(int'($urandom_range(1, 6)), int'($urandom_range(0, 3)),
              int'($urandom_range(1, 3)), ($urandom_range(0, 1) == 0) ? 0 : 2,
              0, 1'b0);
    end
    run_seq(int'($urandom_range(6, 12)), 0, 0, 2, int'($urandom_range(1, 5)), 1'b0);

    // Asynchronous reset mid-burst.
    burstLen = CW'(16); gapLen = '0; numBursts = '0; start = 1'b1; outReady = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    check("pre_reset_valid", RW'(outValid), RW'(1'b1));
    rst = 1'b1;
    #1;
    check("async_rst_outValid", RW'(outValid), RW'(1'b0));
    check("async_rst_srcEn", RW'(srcEn), RW'(1'b0));
    check("async_rst_busy", RW'(busy), RW'(1'b0));
    check("async_rst_outData", outData, RW'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    run_seq(2, 0, 1, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/file_source_pacer.md
Name: file_source_pacer

Overview:
- Sequences a file-driven sample source (one row of DATA_NUM signed words per enabled clock) into bursts separated by programmable gaps.
- Converts the source's free-running enable interface into a valid/ready stream. A 2-entry buffer absorbs the source's one-cycle read latency so no row is dropped or duplicated under backpressure.
- Sits between the simulation/test data source and the DSP datapath under test.

Parameters:
DATA_WIDTH, 16, width of each signed word in a row
DATA_NUM, 8, words per row
CNT_WIDTH, 16, width of burst, gap and burst-count counters

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  pulse; latches config and begins sequencing
stop  in  1  level/pulse; ends issuing early
burstLen  in  CNT_WIDTH  rows per burst (latched at start)
gapLen  in  CNT_WIDTH  idle cycles between bursts (latched at start)
numBursts  in  CNT_WIDTH  bursts to run; 0 = run until stop (latched at start)
srcEn  out  1  enable to source; each high cycle reads one row
srcData  in  DATA_WIDTH x DATA_NUM  source row, valid the cycle after srcEn was high
outValid  out  1  outData holds a row
outReady  in  1  downstream accepts row when outValid && outReady
outData  out  DATA_WIDTH x DATA_NUM  signed row to datapath
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when sequence completes

Behaviour:
- Reset (async, immediate): srcEn=0, outValid=0, outData=all 0, busy=0, done=0, state IDLE, buffer empty, all counters 0. Any in-flight row is discarded. The source is not reset by this block.
- inflight = registered srcEn of the previous cycle; push into buffer when inflight=1 (captures srcData). pop = outValid && outReady. Push and pop in the same cycle are legal.
- occ = buffer occupancy (0..2). outValid = (occ != 0). outData = head entry, held stable while outValid && !outReady.
- srcEn = (state==RUN) && !stop && rowCnt<burstLen && (occ + inflight - pop) <= 1. This is a combinational path from outReady and stop.
- Throughput: with outReady held high, one row per cycle, 2-cycle latency from srcEn to first outValid.
- States:
  - IDLE: on start && !stop, latch config. If burstLen==0, pulse done next cycle and stay IDLE. Otherwise go to RUN with rowCnt=0 and burstCnt=0, so srcEn can be high in the cycle after start.
  - RUN: rowCnt increments on each srcEn cycle. When the last row of a burst is issued, burstCnt increments. Then:
    - if numBursts!=0 and burstCnt reaches numBursts, go to DRAIN;
    - else if gapLen>0, go to GAP with gapCnt=0;
    - else stay in RUN with rowCnt cleared.
  - GAP: srcEn=0; gapCnt increments each cycle; after gapLen cycles, go to RUN with rowCnt=0.
  - DRAIN: srcEn=0; when occ==0 && inflight==0, pulse done for 1 cycle and go to IDLE.
- stop sampled high in RUN or GAP: srcEn low in that same cycle, next state DRAIN. Rows already in flight or buffered are still delivered. stop in IDLE or DRAIN has no effect.
- start while busy: ignored, including config inputs. start && stop together in IDLE: start ignored.
- Buffer never overflows by construction; a simulation assertion flags push when occ==2 && !pop.
- Counters: unsigned compares; no wrap within a sequence. numBursts=0 disables burstCnt terminal compare only.

Test Plan:
1. burstLen=4, gapLen=0, numBursts=1, outReady=1, source model emits incrementing rows -> srcEn high exactly 4 cycles starting cycle after start; outValid 4 consecutive cycles with rows 0,1,2,3; done pulses 1 cycle after last beat; busy then low.
2. burstLen=3, gapLen=2, numBursts=2, outReady=1 -> srcEn pattern 1,1,1,0,0,1,1,1; rows 0..5 delivered in order; single done pulse.
3. burstLen=8, gapLen=0, numBursts=1, outReady toggling 1,0,1,0 -> exactly rows 0..7 in order, no loss/dup; occ never exceeds 2; srcEn low whenever occ+inflight-pop>1; outData stable while stalled.
4. burstLen=16, gapLen=0, numBursts=0; stop asserted after 5 srcEn cycles -> srcEn low in stop cycle; rows 0..4 all delivered; done pulses after drain; busy low; a later start runs normally.
5. start with burstLen=0 -> done pulses next cycle; srcEn never high; busy stays 0. Also start while busy -> no change to latched config or sequence.
6. rst asserted mid-burst between clock edges with outValid=1 -> outValid, srcEn, busy, outData go 0 immediately without a clock edge; after release, a fresh start (burstLen=2, gapLen=0, numBursts=1) delivers exactly 2 rows, then done.
